clk_div_ratio_meter: RTL and testbench
======================================

Name: clk_div_ratio_meter

Overview:
Measuring end of the clock-divider family: takes a divided clock (even or odd ratio) as an asynchronous input sampled in the fast clk domain. Reports its period, high time and low time in clk cycles, ratio parity, and a lock flag once the ratio is stable. Used for self-check of divider outputs and for on-chip ratio monitoring.

Parameters:
MAX_N, 256, maximum measurable period (and phase length) in clk cycles
CW, $clog2(MAX_N+1), width of count outputs (derived, not overridden)
LOCK_CNT, 4, consecutive equal periods required to assert locked
SYNC_STAGES, 2, synchronizer depth for sig_in (>=2)

Ports:
clk  in  1  measurement clock
rst_n  in  1  reset, asynchronous, active-low
sig_in  in  1  divided clock under test, asynchronous to clk
clr  in  1  synchronous clear of state, sticky flags and lock
period  out  CW  last measured period (high_time+low_time)
high_time  out  CW  last measured high phase, clk cycles
low_time  out  CW  last measured low phase, clk cycles
meas_valid  out  1  one-cycle pulse when period/high/low update
is_even  out  1  period[0]==0 for last measurement
locked  out  1  ratio stable for LOCK_CNT consecutive matches
overflow  out  1  sticky: a phase exceeded MAX_N
duty_err  out  1  see Optional Feature

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, match count 0.
- sig_in passes through SYNC_STAGES flops; s = synced value, s_d = s delayed one cycle; rise = s & ~s_d, fall = ~s & s_d.
- FSM states: IDLE, MEAS_HIGH, MEAS_LOW.
- IDLE: on rise -> MEAS_HIGH, cnt <= 1. Falls ignored (partial first period is discarded).
- MEAS_HIGH: cnt increments each cycle; on fall -> hi_r <= cnt, cnt <= 1, go to MEAS_LOW.
- MEAS_LOW: cnt increments; on rise -> high_time <= hi_r, low_time <= cnt, period <= hi_r+cnt, is_even <= ~(hi_r+cnt)[0], meas_valid = 1 next cycle only. cnt <= 1, go to MEAS_HIGH (back-to-back measurements, no gap).
- Outputs are registered; they are stable whenever meas_valid is high and are held until the next measurement.
- Ratio N of sig_in gives period=N. An even divider gives high_time=low_time=N/2.
- Sum is computed at CW+1 bits. If sum > MAX_N, this counts as overflow.
- Overflow: cnt reaches MAX_N in either phase without an edge, or sum > MAX_N. Result: overflow <= 1 (sticky), locked <= 0, match count <= 0, FSM -> IDLE, no meas_valid.
- Lock:
  - First measurement after IDLE sets prev_period; match count stays 0.
  - Each later measurement: period == prev_period increments the match count (saturating at LOCK_CNT); otherwise the count is cleared.
  - locked = (match count == LOCK_CNT), updated in the same cycle as meas_valid.
  - A mismatch drops locked in the same cycle the new meas_valid asserts.
- clr: synchronous; equivalent to reset except the synchronizer is not cleared. clr has priority over any simultaneous edge or overflow event.
- Async reset mid-measurement: outputs clear immediately. After release, the FSM waits for a full rise-fall-rise before the first meas_valid.
- Minimum resolvable phase is 2 clk cycles; shorter pulses may be missed and are not flagged.
- Latency: sig_in rise to meas_valid = SYNC_STAGES+2 clk cycles.

Optional Feature:
DUTY_CHECK_EN.
- Defined: duty_err registers with meas_valid, = 1 when |high_time - low_time| > 1 (not a 50% even or balanced odd divider). Cleared by reset, clr, or a subsequent good measurement.
- Undefined: duty_err is tied to 0 and no comparator is built.

Decomposition:
- Package clk_div_pkg holds:
  - the FSM state enum typedef (meas_state_e: IDLE, MEAS_HIGH, MEAS_LOW);
  - default constants for MAX_N, LOCK_CNT and SYNC_STAGES;
  - a function computing CW.
- One sub-module, sync_bit: parameterized SYNC_STAGES flop chain with async active-low reset, used for sig_in.

Test Plan:
1. sig_in = clk/8 (4 high/4 low). Required: first meas_valid gives period=8, high=4, low=4, is_even=1. locked=1 on the 5th meas_valid.
2. sig_in = clk/5 (3 high/2 low). Required: period=5, high=3, low=2, is_even=0. duty_err=0 with DUTY_CHECK_EN.
3. sig_in = 6 high/2 low. Required: period=8, duty_err=1 (with macro) and 0 (without).
4. Locked on clk/8, then switch to clk/6. Required: first period=6 measurement drops locked in the same cycle; locked re-asserts on the 5th period=6 measurement.
5. Hold sig_in high for 300 cycles with MAX_N=256. Required: overflow=1, locked=0, no meas_valid. Then clr pulse: overflow=0; next full period measures normally.
6. Assert rst_n low mid-MEAS_LOW. Required: all outputs 0 immediately. Separately, clr in the same cycle as a rise: no meas_valid, FSM goes to IDLE.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the divided-clock ratio meter.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEAS_HIGH,
    MEAS_LOW
  } meas_state_e;

  localparam int unsigned DefMaxN       = 256;
  localparam int unsigned DefLockCnt    = 4;
  localparam int unsigned DefSyncStages = 2;

  // Width needed to hold counts 0..max_n inclusive.
  function automatic int unsigned calc_cw(input int unsigned max_n);
    return $clog2(max_n + 1);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit.
module sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clk_div_ratio_meter.sv
// Measures period/high/low of an asynchronous divided clock and flags lock and overflow.
// Optional duty-cycle checker built when DUTY_CHECK_EN is defined.
module clk_div_ratio_meter
  import clk_div_pkg::*;
#(
  parameter int unsigned MAX_N       = DefMaxN,
  parameter int unsigned LOCK_CNT    = DefLockCnt,
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  localparam int unsigned CW         = calc_cw(MAX_N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sig_in,
  input  logic          clr,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic [CW-1:0] low_time,
  output logic          meas_valid,
  output logic          is_even,
  output logic          locked,
  output logic          overflow,
  output logic          duty_err
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] MaxCnt  = CW'(MAX_N);
  localparam logic [CW:0]   MaxSum  = (CW + 1)'(MAX_N);
  localparam logic [MW-1:0] LockVal = MW'(LOCK_CNT);

  logic s;
  logic s_d_q;
  logic rise_q, fall_q;

  meas_state_e   state_q;
  logic [CW-1:0] cnt_q, hi_q;
  logic [CW-1:0] period_q, high_q, low_q;
  logic [CW-1:0] prev_q;
  logic          have_prev_q;
  logic [MW-1:0] match_q;
  logic          mv_q, even_q, locked_q, ovf_q;

  logic [CW:0]   sum;
  logic          sum_ovf;
  logic [MW-1:0] match_nxt;
  logic          ovf_evt;
  logic          duty_nxt;

  sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   (sig_in),
    .q_o   (s)
  );

  // s_d_q belongs to the synchronizer side and survives clr to avoid a fake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s_d_q <= s;
      if (clr) begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= s & ~s_d_q;
        fall_q <= ~s & s_d_q;
      end
    end
  end

  always_comb begin
    sum       = {1'b0, hi_q} + {1'b0, cnt_q};
    sum_ovf   = (sum > MaxSum);
    match_nxt = '0;
    if (have_prev_q && (sum[CW-1:0] == prev_q)) begin
      match_nxt = (match_q == LockVal) ? match_q : match_q + MW'(1);
    end
    ovf_evt = 1'b0;
    case (state_q)
      MEAS_HIGH: ovf_evt = !fall_q && (cnt_q == MaxCnt);
      MEAS_LOW:  ovf_evt = rise_q ? sum_ovf : (cnt_q == MaxCnt);
      default:   ovf_evt = 1'b0;
    endcase
  end

`ifdef DUTY_CHECK_EN
  logic [CW-1:0] diff;
  logic          duty_q;

  always_comb begin
    diff     = (hi_q > cnt_q) ? (hi_q - cnt_q) : (cnt_q - hi_q);
    duty_nxt = (diff > CW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= 1'b0;
    end else if (clr) begin
      duty_q <= 1'b0;
    end else if (state_q == MEAS_LOW && rise_q && !ovf_evt) begin
      duty_q <= duty_nxt;
    end
  end

  assign duty_err = duty_q;
`else
  assign duty_nxt = 1'b0;
  assign duty_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      period_q    <= '0;
      high_q      <= '0;
      low_q       <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      match_q     <= '0;
      mv_q        <= 1'b0;
      even_q      <= 1'b0;
      locked_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      mv_q <= 1'b0;
      if (clr) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        hi_q        <= '0;
        period_q    <= '0;
        high_q      <= '0;
        low_q       <= '0;
        prev_q      <= '0;
        have_prev_q <= 1'b0;
        match_q     <= '0;
        even_q      <= 1'b0;
        locked_q    <= 1'b0;
        ovf_q       <= 1'b0;
      end else if (ovf_evt) begin
        // Abandon the measurement; lock history restarts from the next full period.
        state_q     <= IDLE;
        cnt_q       <= '0;
        ovf_q       <= 1'b1;
        locked_q    <= 1'b0;
        match_q     <= '0;
        have_prev_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise_q) begin
              state_q <= MEAS_HIGH;
              cnt_q   <= CW'(1);
            end
          end
          MEAS_HIGH: begin
            if (fall_q) begin
              hi_q    <= cnt_q;
              cnt_q   <= CW'(1);
              state_q <= MEAS_LOW;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          MEAS_LOW: begin
            if (rise_q) begin
              high_q      <= hi_q;
              low_q       <= cnt_q;
              period_q    <= sum[CW-1:0];
              even_q      <= ~sum[0];
              mv_q        <= 1'b1;
              prev_q      <= sum[CW-1:0];
              have_prev_q <= 1'b1;
              match_q     <= match_nxt;
              locked_q    <= (match_nxt == LockVal);
              cnt_q       <= CW'(1);
              state_q     <= MEAS_HIGH;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign low_time   = low_q;
  assign meas_valid = mv_q;
  assign is_even    = even_q;
  assign locked     = locked_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_clk_div_ratio_meter.sv
// Directed bench for clk_div_ratio_meter; expected duty_err follows DUTY_CHECK_EN.
module tb_clk_div_ratio_meter;

  localparam int CW = 9;
`ifdef DUTY_CHECK_EN
  localparam logic DutyOn = 1'b1;
`else
  localparam logic DutyOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sig_in;
  logic          clr;
  logic [CW-1:0] period, high_time, low_time;
  logic          meas_valid, is_even, locked, overflow, duty_err;

  int n_checks = 0;
  int n_pass   = 0;
  int mv_cnt   = 0;

  // Waveform generator state: new lengths take effect at the next rise.
  logic gen_en = 1'b0;
  int   ph = 0;
  int   hi_len = 4, lo_len = 4, pend_hi = 4, pend_lo = 4;

  always #5 clk = ~clk;

  clk_div_ratio_meter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .clr       (clr),
    .period    (period),
    .high_time (high_time),
    .low_time  (low_time),
    .meas_valid(meas_valid),
    .is_even   (is_even),
    .locked    (locked),
    .overflow  (overflow),
    .duty_err  (duty_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    if (gen_en) begin
      ph++;
      if (sig_in && ph >= hi_len) begin
        sig_in = 1'b0;
        ph = 0;
      end else if (!sig_in && ph >= lo_len) begin
        sig_in = 1'b1;
        ph = 0;
        hi_len = pend_hi;
        lo_len = pend_lo;
      end
    end
    @(posedge clk);
    #1;
    if (meas_valid) mv_cnt++;
  endtask

  task automatic wait_meas(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!meas_valid && n < 400);
    check(tag, 32'(meas_valid), 32'd1);
  endtask

  task automatic set_wave(input int h, input int l);
    pend_hi = h;
    pend_lo = l;
  endtask

  task automatic check_meas(input string tag, input int p, input int h, input int l,
                            input logic ev);
    check({tag, "_period"}, 32'(period), 32'(p));
    check({tag, "_high"},   32'(high_time), 32'(h));
    check({tag, "_low"},    32'(low_time), 32'(l));
    check({tag, "_even"},   32'(is_even), 32'(ev));
  endtask

  initial begin
    rst_n  = 1'b0;
    clr    = 1'b0;
    sig_in = 1'b0;
    repeat (3) step();
    check("rst_period", 32'(period), 32'd0);
    check("rst_high", 32'(high_time), 32'd0);
    check("rst_low", 32'(low_time), 32'd0);
    check("rst_mv", 32'(meas_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_duty", 32'(duty_err), 32'd0);
    rst_n = 1'b1;

    // clk/8, 4 high / 4 low: lock on the 5th measurement
    gen_en = 1'b1;
    wait_meas("t1_m1");
    check_meas("t1", 8, 4, 4, 1'b1);
    check("t1_duty", 32'(duty_err), 32'd0);
    check("t1_lock1", 32'(locked), 32'd0);
    repeat (3) wait_meas("t1_mx");
    check("t1_lock4", 32'(locked), 32'd0);
    wait_meas("t1_m5");
    check("t1_lock5", 32'(locked), 32'd1);

    // clk/5, 3 high / 2 low
    set_wave(3, 2);
    wait_meas("t2_old");
    wait_meas("t2_new");
    check_meas("t2", 5, 3, 2, 1'b0);
    check("t2_duty", 32'(duty_err), 32'd0);
    check("t2_lock", 32'(locked), 32'd0);

    // 6 high / 2 low: unbalanced duty
    set_wave(6, 2);
    wait_meas("t3_old");
    wait_meas("t3_new");
    check_meas("t3", 8, 6, 2, 1'b1);
    check("t3_duty", 32'(duty_err), 32'(DutyOn));

    // Relock on clk/8, then switch to clk/6
    set_wave(4, 4);
    repeat (6) wait_meas("t4_m8");
    check("t4_lock8", 32'(locked), 32'd1);
    check("t4_high8", 32'(high_time), 32'd4);
    check("t4_duty8", 32'(duty_err), 32'd0);
    set_wave(3, 3);
    wait_meas("t4_last8");
    check("t4_last8_period", 32'(period), 32'd8);
    check("t4_last8_lock", 32'(locked), 32'd1);
    wait_meas("t4_first6");
    check_meas("t4_first6", 6, 3, 3, 1'b1);
    check("t4_first6_lock", 32'(locked), 32'd0);
    repeat (3) wait_meas("t4_m6");
    check("t4_4th6_lock", 32'(locked), 32'd0);
    wait_meas("t4_5th6");
    check("t4_5th6_lock", 32'(locked), 32'd1);

    // Hold high past MAX_N: overflow, lock lost, no measurement
    gen_en = 1'b0;
    sig_in = 1'b0;
    repeat (10) step();
    sig_in = 1'b1;
    repeat (6) step();
    mv_cnt = 0;
    repeat (300) step();
    check("t5_ovf", 32'(overflow), 32'd1);
    check("t5_lock", 32'(locked), 32'd0);
    check("t5_no_mv", 32'(mv_cnt), 32'd0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t5_clr_ovf", 32'(overflow), 32'd0);
    check("t5_clr_period", 32'(period), 32'd0);
    ph = 0;
    set_wave(4, 4);
    hi_len = 4;
    lo_len = 4;
    gen_en = 1'b1;
    wait_meas("t5_after");
    check_meas("t5_after", 8, 4, 4, 1'b1);
    check("t5_after_ovf", 32'(overflow), 32'd0);

    // Async reset in the low phase clears outputs at once
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    check("t6_rst_period", 32'(period), 32'd0);
    check("t6_rst_high", 32'(high_time), 32'd0);
    check("t6_rst_even", 32'(is_even), 32'd0);
    begin
      int n = 0;
      do begin
        step();
        n++;
      end while (!(sig_in == 1'b0 && ph == 1) && n < 40);
    end
    rst_n = 1'b1;
    wait_meas("t6_after_rst");
    check_meas("t6_after_rst", 8, 4, 4, 1'b1);

    // clr coinciding with the rise that would complete a measurement
    repeat (7) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t6_clr_mv", 32'(meas_valid), 32'd0);
    check("t6_clr_period", 32'(period), 32'd0);
    mv_cnt = 0;
    repeat (15) step();
    check("t6_idle_no_mv", 32'(mv_cnt), 32'd0);
    step();
    check("t6_resume_mv", 32'(meas_valid), 32'd1);
    check("t6_resume_period", 32'(period), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
